// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM state type and byte/word helpers.
// Byte 0 of a 128-bit block sits in bits [127:120]; columns are 32-bit words.
package aes_pkg;

  localparam int NR = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Forward S-box, entry 0 first (row-major 16x16).
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Rcon for rounds 1..10.
  localparam logic [0:NR-1][7:0] RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  // Out-of-range rounds occur only outside BUSY, where the result is unused.
  function automatic logic [7:0] rcon_of(input logic [3:0] round);
    if (round >= 4'd1 && round <= 4'(NR)) return RCON[round - 4'd1];
    return 8'h00;
  endfunction

  function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, w0, w1, w2, w3;
    t  = sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h0};
    w0 = k[127:96] ^ t;
    w1 = k[95:64]  ^ w0;
    w2 = k[63:32]  ^ w1;
    w3 = k[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES encryption round: SubBytes, ShiftRows,
// MixColumns (bypassed for the final round) and AddRoundKey.
module aes_round
  import aes_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] rkey_i,
  input  logic         last_i,
  output logic [127:0] state_o
);

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  logic [127:0] sr;
  logic [127:0] mc;

  // Byte (row r, column c) of the output comes from column (c + r) mod 4.
  always_comb begin
    sr = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[127 - 8*(4*c + r) -: 8] = SBOX[state_i[127 - 8*(4*((c + r) % 4) + r) -: 8]];
      end
    end
  end

  always_comb begin
    mc = '0;
    for (int c = 0; c < 4; c++) begin
      mc[127 - 32*c -: 32] = mix_column(sr[127 - 32*c -: 32]);
    end
  end

  assign state_o = (last_i ? sr : mc) ^ rkey_i;

endmodule

// File: rtl/aes_round_iter.sv
// Iterative AES-128 encryptor evaluating RPC rounds per clock with an
// on-the-fly key schedule and a valid/ready handshake on both sides.
module aes_round_iter
  import aes_pkg::*;
#(
  parameter int RPC = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  input  logic [127:0] key_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic         busy
);

  if (RPC < 1 || RPC > NR || (NR % RPC) != 0) begin : g_bad_rpc
    $error("aes_round_iter: RPC must divide 10 (1, 2, 5 or 10)");
  end

  state_e       fsm_q, fsm_d;
  logic [127:0] blk_q, blk_d;
  logic [127:0] rkey_q, rkey_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] dout_q, dout_d;
  logic [127:0] blk_last, key_last;

  // Round j of this cycle is round cnt_q+j+1 overall; its key is derived here.
  for (genvar j = 0; j < RPC; j++) begin : g_stage
    logic [3:0]   rnd;
    logic [127:0] blk_in, key_prev, blk_out, key_out;

    assign rnd = cnt_q + 4'(j + 1);

    if (j == 0) begin : g_first
      assign blk_in   = blk_q;
      assign key_prev = rkey_q;
    end else begin : g_next
      assign blk_in   = g_stage[j-1].blk_out;
      assign key_prev = g_stage[j-1].key_out;
    end

    assign key_out = key_step(key_prev, rcon_of(rnd));

    aes_round u_round (
      .state_i (blk_in),
      .rkey_i  (key_out),
      .last_i  (rnd == 4'(NR)),
      .state_o (blk_out)
    );
  end

  assign blk_last = g_stage[RPC-1].blk_out;
  assign key_last = g_stage[RPC-1].key_out;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    fsm_d  = fsm_q;
    blk_d  = blk_q;
    rkey_d = rkey_q;
    cnt_d  = cnt_q;
    dout_d = dout_q;
    unique case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          blk_d  = data_in ^ key_in;
          rkey_d = key_in;
          cnt_d  = '0;
          fsm_d  = BUSY;
        end
      end
      BUSY: begin
        blk_d  = blk_last;
        rkey_d = key_last;
        cnt_d  = cnt_q + 4'(RPC);
        if (cnt_q + 4'(RPC) == 4'(NR)) begin
          dout_d = blk_last;
          fsm_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q  <= IDLE;
      blk_q  <= '0;
      rkey_q <= '0;
      cnt_q  <= '0;
      dout_q <= '0;
    end else begin
      fsm_q  <= fsm_d;
      blk_q  <= blk_d;
      rkey_q <= rkey_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
    end
  end

  assign in_ready  = (fsm_q == IDLE);
  assign busy      = (fsm_q == BUSY);
  assign out_valid = (fsm_q == DONE);
  assign data_out  = dout_q;

endmodule

// File: tb/tb_aes_round_iter.sv
// Directed and streaming bench for aes_round_iter at RPC = 1, 2, 5 and 10,
// with an independent table-free AES-128 reference model.
module tb_aes_round_iter;

  localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;

  function automatic int rpc_of(input int k);
    case (k)
      0:       return 1;
      1:       return 2;
      2:       return 5;
      default: return 10;
    endcase
  endfunction

  logic         clk;
  logic         rst_n;
  logic [127:0] data_in, key_in;
  logic [3:0]   iv, irdy, ov, ordy, bsy;
  logic [127:0] dout [4];
  logic [127:0] last_ct [4];
  logic [7:0]   sb_t [256];

  int checks = 0;
  int errors = 0;

  for (genvar k = 0; k < 4; k++) begin : g_dut
    aes_round_iter #(.RPC(rpc_of(k))) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv[k]),
      .in_ready  (irdy[k]),
      .data_in   (data_in),
      .key_in    (key_in),
      .out_valid (ov[k]),
      .out_ready (ordy[k]),
      .data_out  (dout[k]),
      .busy      (bsy[k])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (CHECKS %0d ERRORS %0d)", checks, errors);
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b  = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  // S-box derived from the GF(2^8) inverse and the affine map.
  task automatic build_sbox();
    logic [7:0] inv, x8, y8;
    for (int x = 0; x < 256; x++) begin
      x8  = 8'(x);
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        y8 = 8'(y);
        if (gmul(x8, y8) == 8'h01) inv = y8;
      end
      sb_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] ref_aes(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [7:0]   s [16];
    logic [7:0]   u [16];
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sb_t[t[31:24]], sb_t[t[23:16]], sb_t[t[15:8]], sb_t[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ w[i/4][31 - 8*(i%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) u[i] = sb_t[s[4*((i/4 + i%4) % 4) + i%4]];
      for (int c = 0; c < 4; c++) begin
        for (int r = 0; r < 4; r++) begin
          if (rnd < 10)
            s[4*c + r] = gmul(8'h02, u[4*c + r]) ^ gmul(8'h03, u[4*c + (r+1)%4])
                       ^ u[4*c + (r+2)%4] ^ u[4*c + (r+3)%4];
          else
            s[4*c + r] = u[4*c + r];
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31 - 8*(i%4) -: 8];
    end
    res = '0;
    for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_block(input int k, input logic [127:0] key, input logic [127:0] pt);
    int g;
    g = 0;
    while (irdy[k] !== 1'b1 && g < 40) begin
      tick();
      g++;
    end
    data_in = pt;
    key_in  = key;
    iv[k]   = 1'b1;
    tick();
    iv[k]   = 1'b0;
  endtask

  // Called just after the accept edge: measures latency, checks, then handshakes.
  task automatic finish_block(input int k, input logic [127:0] exp, input string tag, input int stall);
    int n;
    check({tag, "_busy"}, 128'(bsy[k]), 128'd1);
    check({tag, "_hold_prev"}, dout[k], last_ct[k]);
    n = 0;
    while (ov[k] !== 1'b1 && n < 40) begin
      ordy[k] = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    ordy[k] = 1'b0;
    check({tag, "_latency"}, 128'(n), 128'(10 / rpc_of(k)));
    check({tag, "_data"}, dout[k], exp);
    for (int i = 0; i < stall; i++) begin
      tick();
      check({tag, "_stall_valid"}, 128'(ov[k]), 128'd1);
      check({tag, "_stall_data"}, dout[k], exp);
    end
    last_ct[k] = exp;
    ordy[k] = 1'b1;
    tick();
    ordy[k] = 1'b0;
    check({tag, "_post_valid"}, 128'(ov[k]), 128'd0);
    check({tag, "_post_ready"}, 128'(irdy[k]), 128'd1);
    check({tag, "_post_data"}, dout[k], exp);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [127:0] rk, rp, rexp;
    int           nov;

    rst_n   = 1'b0;
    iv      = '0;
    ordy    = '0;
    data_in = '0;
    key_in  = '0;
    for (int k = 0; k < 4; k++) last_ct[k] = '0;
    build_sbox();

    #3;
    check("rst_in_ready", 128'(irdy), 128'hf);
    check("rst_out_valid", 128'(ov), 128'h0);
    check("rst_busy", 128'(bsy), 128'h0);
    check("rst_data_out", dout[0], 128'h0);

    // Accept on the first edge after reset release.
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    data_in = P_C1;
    key_in  = K_C1;
    iv[0]   = 1'b1;
    tick();
    iv[0]   = 1'b0;
    check("first_accept_busy", 128'(bsy[0]), 128'd1);
    finish_block(0, CT_C1, "c1_rpc1", 0);

    for (int k = 1; k < 4; k++) begin
      start_block(k, K_C1, P_C1);
      finish_block(k, CT_C1, $sformatf("c1_rpc%0d", rpc_of(k)), 0);
    end

    start_block(0, K_B, P_B);
    finish_block(0, CT_B, "fips_b", 0);

    // Backpressure: 7 stalled cycles in DONE with in_valid pulses.
    start_block(0, K_B, P_B);
    nov = 0;
    while (ov[0] !== 1'b1 && nov < 40) begin
      tick();
      nov++;
    end
    check("bp_reach_done", 128'(ov[0]), 128'd1);
    for (int i = 0; i < 7; i++) begin
      data_in = P_C1;
      key_in  = K_C1;
      iv[0]   = (i % 2 == 0);
      tick();
      check("bp_valid", 128'(ov[0]), 128'd1);
      check("bp_data", dout[0], CT_B);
      check("bp_no_ready", 128'(irdy[0]), 128'd0);
    end
    iv[0]   = 1'b1;
    ordy[0] = 1'b1;
    tick();
    ordy[0] = 1'b0;
    check("bp_no_same_cycle_accept", 128'(bsy[0]), 128'd0);
    check("bp_idle_after_hs", 128'(irdy[0]), 128'd1);
    tick();
    iv[0] = 1'b0;
    last_ct[0] = CT_B;
    finish_block(0, CT_C1, "bp_next", 0);

    // in_valid held with a different pair during BUSY.
    data_in = P_B;
    key_in  = K_B;
    iv[0]   = 1'b1;
    tick();
    data_in = P_C1;
    key_in  = K_C1;
    finish_block(0, CT_B, "hold_valid", 0);
    iv[0] = 1'b0;

    // Reset in BUSY cycle 3.
    start_block(0, K_C1, P_C1);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 128'(irdy[0]), 128'd1);
    check("midrst_out_valid", 128'(ov[0]), 128'd0);
    check("midrst_busy", 128'(bsy[0]), 128'd0);
    check("midrst_data_out", dout[0], 128'h0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) last_ct[k] = '0;
    nov = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ov[0] === 1'b1) nov++;
    end
    check("midrst_no_out_valid", 128'(nov), 128'd0);
    start_block(0, K_C1, P_C1);
    finish_block(0, CT_C1, "after_rst", 0);

    // Streaming random pairs with random consumer stalls.
    for (int n = 0; n < 100; n++) begin
      rk   = {$urandom, $urandom, $urandom, $urandom};
      rp   = {$urandom, $urandom, $urandom, $urandom};
      rexp = ref_aes(rk, rp);
      for (int i = 0; i < int'($urandom_range(0, 2)); i++) tick();
      start_block(0, rk, rp);
      finish_block(0, rexp, $sformatf("stream%0d", n), int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_round_iter.md
AES_ROUND_ITER -- requirements
Module: aes_round_iter

Interface
REQ-001 SHALL have parameter RPC, default 1: AES rounds evaluated per clock; legal values 1, 2, 5, 10.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: a plaintext/key pair is offered.
REQ-005 SHALL have port in_ready, output, 1 bit: the block can accept a pair.
REQ-006 SHALL have port data_in, input, 128 bits: plaintext; bits [127:120] are FIPS-197 byte 0.
REQ-007 SHALL have port key_in, input, 128 bits: AES-128 cipher key, same byte order as data_in.
REQ-008 SHALL have port out_valid, output, 1 bit: ciphertext is valid.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer accepts the ciphertext.
REQ-010 SHALL have port data_out, output, 128 bits: ciphertext, same byte order as data_in.
REQ-011 SHALL have port busy, output, 1 bit: high while in the BUSY state.

Function
REQ-012 SHALL implement FIPS-197 AES-128 encryption (NR=10 rounds), computing the round keys on the fly with no key RAM.
REQ-013 SHALL implement an FSM with three states: IDLE, BUSY and DONE.
REQ-014 SHALL assert in_ready only in IDLE.
REQ-015 SHALL assert out_valid only in DONE.
REQ-016 SHALL assert busy only in BUSY.
REQ-017 On an accept (IDLE and in_valid), SHALL register state = data_in XOR key_in, round key = key_in and round counter = 0, then enter BUSY.
REQ-018 In BUSY, SHALL apply RPC consecutive rounds per cycle, advancing the round key through the key schedule once per round with Rcon[round] and adding RPC to the counter.
REQ-019 SHALL omit MixColumns only in round 10; rounds 1 to 9 are full rounds.
REQ-020 When the counter reaches 10, SHALL enter DONE with data_out holding the ciphertext.
REQ-021 Latency SHALL be exactly 10/RPC cycles from the accept edge to out_valid high.
REQ-022 SHALL hold data_out and out_valid stable in DONE until out_ready is high; on that edge it returns to IDLE.
REQ-023 Peak throughput SHALL be one block per 10/RPC+2 cycles.
REQ-024 SHALL ignore in_valid in BUSY and DONE, with no capture and no state change.
REQ-025 SHALL ignore out_ready outside DONE.
REQ-026 SHALL hold data_out at its last ciphertext in IDLE and BUSY; it is qualified by out_valid only.
REQ-027 SHALL make a back-to-back accept possible only on the cycle after leaving DONE; there is no accept in the same cycle as the output handshake.
REQ-028 An RPC value that does not divide 10 SHALL cause an elaboration-time error.

Reset
REQ-029 While rst_n is low, SHALL force state IDLE, in_ready=1, out_valid=0, busy=0, data_out=0, counter=0, internal state=0 and round key=0, asynchronously.
REQ-030 Reset asserted mid-operation (BUSY or DONE) SHALL discard the block in flight; no out_valid may follow.
REQ-031 After rst_n deasserts, the first accept SHALL be possible on the first rising edge.

Structure
REQ-032 Package aes_pkg SHALL hold: NR=10, the 256-entry S-box table, the Rcon table (10 entries), the FSM state enum, and the functions sub_word and xtime.
REQ-033 Sub-module aes_round (purely combinational) SHALL take state, round key and a last flag, perform SubBytes, ShiftRows, MixColumns (skipped if last) and AddRoundKey, and output the next state.
REQ-034 aes_round_iter SHALL instantiate RPC copies of aes_round chained, plus RPC key-schedule steps.

Verification
REQ-035 FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> data_out 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 10/RPC cycles after accept; run for RPC=1, 2, 5, 10.
REQ-036 FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32.
REQ-037 Backpressure: hold out_ready=0 for 7 cycles in DONE -> data_out and out_valid stable; in_valid pulses during that time are ignored; the next accept is 1 cycle after the handshake.
REQ-038 in_valid held high with a different pair during BUSY -> result equals the first pair's ciphertext only.
REQ-039 rst_n pulsed low at BUSY cycle 3 -> outputs reach reset values immediately, no out_valid; the C.1 vector then passes normally.
REQ-040 Streaming: 100 random pairs with random out_ready stalls -> all results match the reference model in order.
